// File: rtl/ld_sample_seq_if.sv
// Bundle between the rider-sensing round scheduler, its SPI master and the result consumers.
// master = the scheduler side; slave = SPI master / request source / consumers.
interface ld_sample_seq_if;
  logic        nxt;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        vld;
  logic        busy;
  logic        spi_err;

  modport master (
    input  nxt, done, rd_data,
    output wrt, cmd, lft_ld, rght_ld, steer_pot, batt, vld, busy, spi_err
  );

  modport slave (
    output nxt, done, rd_data,
    input  wrt, cmd, lft_ld, rght_ld, steer_pot, batt, vld, busy, spi_err
  );
endinterface

// File: rtl/ld_sample_seq.sv
// Round scheduler for the shared A2D: converts LFT, RGHT, STR, BATT over SPI (two transactions
// each), publishes registered 12-bit results, auto-starts from a period timer, flags a hung SPI.
module ld_sample_seq #(
  parameter bit       fast_sim = 1'b0,
  parameter bit       AUTO     = 1'b1,
  parameter bit [2:0] CH_LFT   = 3'd0,
  parameter bit [2:0] CH_RGHT  = 3'd4,
  parameter bit [2:0] CH_STR   = 3'd5,
  parameter bit [2:0] CH_BATT  = 3'd6
) (
  input logic             clk,
  input logic             rst_n,
  ld_sample_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SEND_A, WAIT_A, GAP, SEND_B, WAIT_B, CAPT, FIN
  } state_t;

  state_t      state, nxt_state;
  logic [1:0]  idx;
  logic        pend;
  logic [21:0] tmr;
  logic [15:0] wdog;
  logic [11:0] lft_q, rght_q, str_q, batt_q;
  logic        err_q;

  logic        tmr_wrap, auto_tick, start, in_wait, wd_full, wd_exp;
  logic [2:0]  ch_sel;
  logic [15:0] acmd;
  logic        unused_rd;

  assign tmr_wrap  = fast_sim ? (&tmr[11:0]) : (&tmr);
  assign auto_tick = AUTO & tmr_wrap;
  assign start     = bus.nxt | auto_tick | pend;
  assign in_wait   = (state == WAIT_A) || (state == WAIT_B);
  assign wd_full   = fast_sim ? (&wdog[7:0]) : (&wdog);
  // A done arriving on the expiry cycle still completes the transaction.
  assign wd_exp    = in_wait & wd_full & ~bus.done;

  assign ch_sel = (idx == 2'd0) ? CH_LFT  :
                  (idx == 2'd1) ? CH_RGHT :
                  (idx == 2'd2) ? CH_STR  : CH_BATT;
  assign acmd   = {2'b00, ch_sel, 11'h000};

  assign unused_rd = ^bus.rd_data[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (start) nxt_state = SEND_A;
      SEND_A:  nxt_state = WAIT_A;
      WAIT_A:  if (bus.done) nxt_state = GAP;
               else if (wd_exp) nxt_state = IDLE;
      GAP:     nxt_state = SEND_B;
      SEND_B:  nxt_state = WAIT_B;
      WAIT_B:  if (bus.done) nxt_state = CAPT;
               else if (wd_exp) nxt_state = IDLE;
      CAPT:    nxt_state = (idx == 2'd3) ? FIN : SEND_A;
      FIN:     nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    bus.wrt  = 1'b0;
    bus.cmd  = 16'h0000;
    bus.vld  = 1'b0;
    bus.busy = (state != IDLE);
    case (state)
      SEND_A: begin
        bus.wrt = 1'b1;
        bus.cmd = acmd;
      end
      WAIT_A:  bus.cmd = acmd;
      SEND_B:  bus.wrt = 1'b1;
      FIN:     bus.vld = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr    <= '0;
      wdog   <= '0;
      idx    <= '0;
      pend   <= 1'b0;
      err_q  <= 1'b0;
      lft_q  <= '0;
      rght_q <= '0;
      str_q  <= '0;
      batt_q <= '0;
    end else begin
      tmr <= tmr + 22'd1;

      if (bus.wrt)      wdog <= '0;
      else if (in_wait) wdog <= wdog + 16'd1;

      if (state == IDLE)      idx <= 2'd0;
      else if (state == CAPT) idx <= idx + 2'd1;

      // Requests seen while busy collapse into one pending start; IDLE consumes it.
      if ((state == IDLE) || wd_exp)  pend <= 1'b0;
      else if (bus.nxt | auto_tick)   pend <= 1'b1;

      if (wd_exp) err_q <= 1'b1;

      if ((state == WAIT_B) && bus.done) begin
        case (idx)
          2'd0:    lft_q  <= bus.rd_data[11:0];
          2'd1:    rght_q <= bus.rd_data[11:0];
          2'd2:    str_q  <= bus.rd_data[11:0];
          default: batt_q <= bus.rd_data[11:0];
        endcase
      end
    end
  end

  assign bus.lft_ld    = lft_q;
  assign bus.rght_ld   = rght_q;
  assign bus.steer_pot = str_q;
  assign bus.batt      = batt_q;
  assign bus.spi_err   = err_q;

endmodule
